sprite_store_n: RTL and testbench
=================================

SPRITE_STORE_N -- requirements
Module: sprite_store_n

Interface
REQ-001 SHALL have parameter SLOTS, default 10, number of sprite entries (2..16).
REQ-002 SHALL have parameter IDX_W, default 6, OAM sprite-index width.
REQ-003 SHALL have parameter LINE_W, default 4, sprite-row (line-within-sprite) width.
REQ-004 SHALL have parameter X_W, default 8, sprite X-coordinate width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports: clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port clear  in  1  line start; empties the store.
REQ-008 SHALL have port wr_valid  in  1  store request from OAM scan.
REQ-009 SHALL have ports wr_idx, wr_line, wr_x  in  IDX_W, LINE_W, X_W  data to store.
REQ-010 SHALL have port full  out  1  all SLOTS entries allocated since last clear.
REQ-011 SHALL have port count  out  $clog2(SLOTS+1)  entries allocated since last clear.
REQ-012 SHALL have ports q_valid, q_x  in  1, X_W  pixel-X lookup request.
REQ-013 SHALL have ports hit_valid, hit_slot, hit_idx, hit_line  out  1, $clog2(SLOTS), IDX_W, LINE_W  lookup result.
REQ-014 SHALL have port consume  in  1  retire the entry reported on hit_*.
REQ-015 SHALL have port ovf  out  1  sticky write-while-full flag.

Function
REQ-016 SHALL allocate entries append-only: write pointer wp selects slot; accepted write stores {idx,line,x}, sets slot valid, increments wp and count.
REQ-017 SHALL accept a write only when wr_valid=1, full=0, clear=0; otherwise the write is dropped with no state change except REQ-029.
REQ-018 SHALL assert full combinationally from count==SLOTS; freed (consumed) slots are never reallocated before clear.
REQ-019 SHALL, on clear, set wp=0, count=0, all valid bits 0 at the next edge; clear beats a same-cycle write and a same-cycle consume.
REQ-020 SHALL, on q_valid, compare q_x against every valid slot's x; lowest-numbered matching slot wins.
REQ-021 SHALL register the lookup: hit_valid/hit_* appear exactly one cycle after q_valid; hit_valid=0 if no match or q_valid=0.
REQ-022 SHALL hold hit_slot/hit_idx/hit_line at their last values when hit_valid=0.
REQ-023 SHALL, when consume=1 and hit_valid=1, clear valid of slot hit_slot at that edge; consume with hit_valid=0 is ignored.
REQ-024 SHALL exclude a slot being consumed this cycle from this cycle's comparison (no double hit).
REQ-025 SHALL allow a write and a consume in the same cycle; both take effect.
REQ-026 SHALL ignore a same-cycle lookup during clear: hit_valid=0 next cycle.

Reset
REQ-027 SHALL, while rst_n=0, force wp=0, count=0, all valid=0, full=0, hit_valid=0, hit_slot/idx/line=0, ovf=0; stored idx/line/x need not reset.
REQ-028 SHALL abort any in-flight lookup on reset; first lookup after release behaves as from empty.

Configuration
REQ-029 SHALL, with SPRITE_STORE_OVF_EN defined, set ovf on any cycle with wr_valid=1, full=1, clear=0 and clear ovf only on clear or reset.
REQ-030 SHALL, without SPRITE_STORE_OVF_EN, drive ovf constant 0 and contain no overflow logic.

Structure
REQ-031 SHALL place default parameter values and a slot typedef {valid, idx, line, x} in shared package sprite_store_pkg.
REQ-032 SHALL instantiate SLOTS copies of sub-module sprite_store_slot (one entry storage plus X comparator); priority select and pointer logic in sprite_store_n.

Verification
REQ-033 SHALL test: reset, write 3 entries x=8,16,8 idx=1,2,3 -> count=3, full=0; q_x=8 -> next cycle hit_valid=1, hit_slot=0, hit_idx=1.
REQ-034 SHALL test: consume that hit, q_x=8 again -> hit_slot=2, hit_idx=3; consume -> q_x=8 -> hit_valid=0.
REQ-035 SHALL test: 10 writes (SLOTS=10) -> full=1, count=10; 11th write -> dropped, count=10, ovf=1 (macro on) / ovf=0 (macro off).
REQ-036 SHALL test: clear with wr_valid=1 same cycle -> count=0, full=0, ovf=0, no slot valid.
REQ-037 SHALL test: consume slot 0 while q_x matches slot 0 and slot 4 in same cycle -> next hit_slot=4.
REQ-038 SHALL test: rst_n pulsed low mid-lookup -> hit_valid=0, count=0 immediately, no hit after release until new writes.

Source files
------------

// File: rtl/sprite_store_pkg.sv
// sprite_store_pkg: default geometry and slot record for the per-line sprite store.
package sprite_store_pkg;
    localparam int SLOTS_DEF  = 10;
    localparam int IDX_W_DEF  = 6;
    localparam int LINE_W_DEF = 4;
    localparam int X_W_DEF    = 8;

    typedef struct packed {
        logic                  valid;
        logic [IDX_W_DEF-1:0]  idx;
        logic [LINE_W_DEF-1:0] line;
        logic [X_W_DEF-1:0]    x;
    } slot_t;
endpackage

// File: rtl/sprite_store_slot.sv
// sprite_store_slot: one sprite entry (valid + idx/line/x) with its X comparator.
module sprite_store_slot
    import sprite_store_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int X_W    = X_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              kill,
    input  logic [IDX_W-1:0]  d_idx,
    input  logic [LINE_W-1:0] d_line,
    input  logic [X_W-1:0]    d_x,
    input  logic [X_W-1:0]    q_x,
    output logic              valid,
    output logic [IDX_W-1:0]  idx,
    output logic [LINE_W-1:0] line,
    output logic              match
);
    logic [X_W-1:0] x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid <= 1'b0;
        else if (clear)
            valid <= 1'b0;
        else if (load)
            valid <= 1'b1;
        else if (kill)
            valid <= 1'b0;
    end

    // Payload needs no reset: it is only observed through a valid slot.
    always_ff @(posedge clk) begin
        if (load) begin
            idx  <= d_idx;
            line <= d_line;
            x    <= d_x;
        end
    end

    // A slot retiring this cycle must not answer this cycle's lookup.
    assign match = valid && !kill && (x == q_x);
endmodule

// File: rtl/sprite_store_n.sv
// sprite_store_n: append-only per-line sprite store with registered X lookup.
// Optional sticky overflow flag enabled by defining SPRITE_STORE_OVF_EN.
module sprite_store_n
    import sprite_store_pkg::*;
#(
    parameter int SLOTS  = SLOTS_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int X_W    = X_W_DEF,
    localparam int CW    = $clog2(SLOTS + 1),
    localparam int SW    = $clog2(SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_valid,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [X_W-1:0]    wr_x,
    output logic              full,
    output logic [CW-1:0]     count,
    input  logic              q_valid,
    input  logic [X_W-1:0]    q_x,
    output logic              hit_valid,
    output logic [SW-1:0]     hit_slot,
    output logic [IDX_W-1:0]  hit_idx,
    output logic [LINE_W-1:0] hit_line,
    input  logic              consume,
    output logic              ovf
);
    logic              accept;
    logic [SLOTS-1:0]  valid, match;
    logic [IDX_W-1:0]  idx_a  [SLOTS];
    logic [LINE_W-1:0] line_a [SLOTS];
    logic              any;
    logic [SW-1:0]     sel;

    assign full   = (count == CW'(SLOTS));
    assign accept = wr_valid && !full && !clear;

    // The write pointer is the allocation count: slots fill in order and are never reused.
    genvar i;
    generate
        for (i = 0; i < SLOTS; i++) begin : g_slot
            sprite_store_slot #(.IDX_W(IDX_W), .LINE_W(LINE_W), .X_W(X_W)) u_slot (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (clear),
                .load  (accept && (count == CW'(i))),
                .kill  (consume && hit_valid && (hit_slot == SW'(i))),
                .d_idx (wr_idx),
                .d_line(wr_line),
                .d_x   (wr_x),
                .q_x   (q_x),
                .valid (valid[i]),
                .idx   (idx_a[i]),
                .line  (line_a[i]),
                .match (match[i])
            );
        end
    endgenerate

    always_comb begin
        any = 1'b0;
        sel = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (q_valid && !clear && match[s]) begin
                any = 1'b1;
                sel = SW'(s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            hit_valid <= 1'b0;
            hit_slot  <= '0;
            hit_idx   <= '0;
            hit_line  <= '0;
        end else begin
            count     <= clear ? '0 : (accept ? count + 1'b1 : count);
            hit_valid <= any;
            if (any) begin
                hit_slot <= sel;
                hit_idx  <= idx_a[sel];
                hit_line <= line_a[sel];
            end
        end
    end

`ifdef SPRITE_STORE_OVF_EN
    logic ovf_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_r <= 1'b0;
        else if (clear)
            ovf_r <= 1'b0;
        else if (wr_valid && full)
            ovf_r <= 1'b1;
    end
    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_store_n.sv
// tb_sprite_store_n: directed self-checking bench for sprite_store_n (default parameters).
module tb_sprite_store_n;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       wr_valid = 1'b0;
    logic [5:0] wr_idx = '0;
    logic [3:0] wr_line = '0;
    logic [7:0] wr_x = '0;
    logic       full;
    logic [3:0] count;
    logic       q_valid = 1'b0;
    logic [7:0] q_x = '0;
    logic       hit_valid;
    logic [3:0] hit_slot;
    logic [5:0] hit_idx;
    logic [3:0] hit_line;
    logic       consume = 1'b0;
    logic       ovf;
    int         n_run = 0;
    int         n_fail = 0;

`ifdef SPRITE_STORE_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    sprite_store_n dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_line(wr_line), .wr_x(wr_x),
        .full(full), .count(count),
        .q_valid(q_valid), .q_x(q_x),
        .hit_valid(hit_valid), .hit_slot(hit_slot), .hit_idx(hit_idx), .hit_line(hit_line),
        .consume(consume), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_run++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic wr(input logic [5:0] i, input logic [3:0] l, input logic [7:0] x);
        wr_valid = 1'b1; wr_idx = i; wr_line = l; wr_x = x;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic look(input logic [7:0] x, input logic c);
        q_valid = 1'b1; q_x = x; consume = c;
        cyc();
        q_valid = 1'b0; consume = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_hit_slot", hit_slot, 0);
        chk("rst_hit_idx", hit_idx, 0);
        chk("rst_hit_line", hit_line, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        cyc();

        wr(1, 5, 8); wr(2, 6, 16); wr(3, 7, 8);
        chk("w3_count", count, 3);
        chk("w3_full", full, 0);
        look(8, 0);
        chk("q1_hit_valid", hit_valid, 1);
        chk("q1_hit_slot", hit_slot, 0);
        chk("q1_hit_idx", hit_idx, 1);
        chk("q1_hit_line", hit_line, 5);
        look(8, 1);
        chk("q2_hit_valid", hit_valid, 1);
        chk("q2_hit_slot", hit_slot, 2);
        chk("q2_hit_idx", hit_idx, 3);
        chk("q2_hit_line", hit_line, 7);
        look(8, 1);
        chk("q3_hit_valid", hit_valid, 0);
        chk("q3_hold_slot", hit_slot, 2);
        chk("q3_hold_idx", hit_idx, 3);
        look(8, 1);
        chk("q4_hit_valid", hit_valid, 0);
        chk("consumed_count", count, 3);
        look(16, 0);
        chk("q5_hit_slot", hit_slot, 1);
        chk("q5_hit_idx", hit_idx, 2);

        for (int k = 0; k < 7; k++) wr(6'(4 + k), 4'(k), 8'(20 + k));
        chk("w10_count", count, 10);
        chk("w10_full", full, 1);
        chk("w10_ovf", ovf, 0);
        wr(11, 1, 99);
        chk("w11_count", count, 10);
        chk("w11_ovf", ovf, OVF_EXP);
        look(99, 0);
        chk("w11_dropped", hit_valid, 0);
        look(26, 0);
        chk("last_slot_hit", hit_slot, 9);
        chk("last_slot_idx", hit_idx, 10);

        clear = 1'b1; wr_valid = 1'b1; wr_idx = 12; wr_x = 20; q_valid = 1'b1; q_x = 20;
        cyc();
        clear = 1'b0; wr_valid = 1'b0; q_valid = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_full", full, 0);
        chk("clr_ovf", ovf, 0);
        chk("clr_lookup", hit_valid, 0);
        look(20, 0);
        chk("clr_no_valid", hit_valid, 0);

        wr(10, 0, 40); wr(11, 1, 1); wr(12, 2, 2); wr(13, 3, 3); wr(14, 4, 40);
        look(40, 0);
        chk("p1_hit_slot", hit_slot, 0);
        chk("p1_hit_idx", hit_idx, 10);
        look(40, 1);
        chk("p2_hit_valid", hit_valid, 1);
        chk("p2_hit_slot", hit_slot, 4);
        chk("p2_hit_idx", hit_idx, 14);
        wr_valid = 1'b1; wr_idx = 15; wr_line = 9; wr_x = 40;
        look(40, 1);
        wr_valid = 1'b0;
        chk("wc_hit_valid", hit_valid, 0);
        chk("wc_count", count, 6);
        look(40, 0);
        chk("wc_hit_slot", hit_slot, 5);
        chk("wc_hit_idx", hit_idx, 15);
        chk("wc_hit_line", hit_line, 9);

        look(1, 0);
        chk("pre_rst_hit", hit_valid, 1);
        q_valid = 1'b1; q_x = 1;
        rst_n = 1'b0;
        #1;
        chk("arst_hit_valid", hit_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_full", full, 0);
        cyc();
        q_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
        chk("post_rst_hit", hit_valid, 0);
        look(1, 0);
        chk("post_rst_lookup", hit_valid, 0);
        wr(20, 3, 1);
        look(1, 0);
        chk("post_rst_wr_hit", hit_valid, 1);
        chk("post_rst_wr_slot", hit_slot, 0);
        chk("post_rst_wr_idx", hit_idx, 20);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
